// File: rtl/tricolor_scan_ctrl_pkg.sv
// Shared definitions for the tricolor scan controller.
//   state_e   : scan FSM states (IDLE, SCAN, DONE)
//   NUM_PAIRS : number of (a,b) operand pairs visited per scan
//   IDX_W     : width of the pair index
//   CNT_W     : width of the per-colour hit counters
package tricolor_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int NUM_PAIRS = 16;
    localparam int IDX_W     = 4;
    localparam int CNT_W     = 5;

endpackage

// File: rtl/tricolor_scan_ctrl_tricolor.sv
// Combinational 2-bit unsigned comparator producing three colour flags.
//   a, b  : 2-bit unsigned operands
//   red   : a >= b
//   green : a <= b
//   blue  : a != b
module tricolor (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       red,
    output logic       green,
    output logic       blue
);

    always_comb begin
        red   = (a >= b);
        green = (a <= b);
        blue  = (a != b);
    end

endmodule

// File: rtl/tricolor_scan_ctrl.sv
// Scans all 16 (a,b) pairs of 2-bit operands through the tricolor comparator,
// holding each pair for dwell+1 cycles and counting how many pairs assert
// each colour.
//   clk, rst              : clock, asynchronous active-high reset
//   start, abort          : scan request (IDLE only) / scan termination
//   dwell                 : extra hold cycles per pair, latched at scan start
//   a_o, b_o              : current operand pair
//   red_o/green_o/blue_o  : comparator result, forced low when not busy
//   busy, done            : scan in progress / one-cycle completion pulse
//   red_cnt/green_cnt/blue_cnt : per-colour hit counts of the last scan
module tricolor_scan_ctrl
    import tricolor_scan_ctrl_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [DWELL_W-1:0] dwell,
    output logic [1:0]         a_o,
    output logic [1:0]         b_o,
    output logic               red_o,
    output logic               green_o,
    output logic               blue_o,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   red_cnt,
    output logic [CNT_W-1:0]   green_cnt,
    output logic [CNT_W-1:0]   blue_cnt
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PAIRS - 1);

    state_e             state_q,     state_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic [DWELL_W-1:0] hold_q,      hold_d;
    logic [DWELL_W-1:0] dwell_lat_q, dwell_lat_d;
    logic [CNT_W-1:0]   red_cnt_q,   red_cnt_d;
    logic [CNT_W-1:0]   green_cnt_q, green_cnt_d;
    logic [CNT_W-1:0]   blue_cnt_q,  blue_cnt_d;

    logic red_raw, green_raw, blue_raw;

    tricolor u_tricolor (
        .a     (idx_q[3:2]),
        .b     (idx_q[1:0]),
        .red   (red_raw),
        .green (green_raw),
        .blue  (blue_raw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            hold_q      <= '0;
            dwell_lat_q <= '0;
            red_cnt_q   <= '0;
            green_cnt_q <= '0;
            blue_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            dwell_lat_q <= dwell_lat_d;
            red_cnt_q   <= red_cnt_d;
            green_cnt_q <= green_cnt_d;
            blue_cnt_q  <= blue_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        dwell_lat_d = dwell_lat_q;
        red_cnt_d   = red_cnt_q;
        green_cnt_d = green_cnt_q;
        blue_cnt_d  = blue_cnt_q;

        case (state_q)
            ST_IDLE: begin
                // abort dominates a simultaneous start
                if (start && !abort) begin
                    state_d     = ST_SCAN;
                    idx_d       = '0;
                    hold_d      = dwell;
                    dwell_lat_d = dwell;
                    red_cnt_d   = '0;
                    green_cnt_d = '0;
                    blue_cnt_d  = '0;
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    // pair in progress is dropped; earlier counts are kept
                    state_d = ST_IDLE;
                end else if (hold_q == '0) begin
                    red_cnt_d   = red_cnt_q   + CNT_W'(red_raw);
                    green_cnt_d = green_cnt_q + CNT_W'(green_raw);
                    blue_cnt_d  = blue_cnt_q  + CNT_W'(blue_raw);
                    // index stays on the last pair so a_o/b_o hold after the scan
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        hold_d = dwell_lat_q;
                    end
                end else begin
                    hold_d = hold_q - DWELL_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (state_q == ST_SCAN);
        done      = (state_q == ST_DONE);
        a_o       = idx_q[3:2];
        b_o       = idx_q[1:0];
        red_o     = red_raw   & busy;
        green_o   = green_raw & busy;
        blue_o    = blue_raw  & busy;
        red_cnt   = red_cnt_q;
        green_cnt = green_cnt_q;
        blue_cnt  = blue_cnt_q;
    end

endmodule

// File: tb/tb_tricolor_scan_ctrl.sv
module tb_tricolor_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] dwell;
    logic [1:0] a_o, b_o;
    logic       red_o, green_o, blue_o;
    logic       busy, done;
    logic [4:0] red_cnt, green_cnt, blue_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic       r;
        logic       g;
        logic       bl;
    } vec_t;

    vec_t tbl [16];

    tricolor_scan_ctrl #(.DWELL_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .dwell     (dwell),
        .a_o       (a_o),
        .b_o       (b_o),
        .red_o     (red_o),
        .green_o   (green_o),
        .blue_o    (blue_o),
        .busy      (busy),
        .done      (done),
        .red_cnt   (red_cnt),
        .green_cnt (green_cnt),
        .blue_cnt  (blue_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_counts(input string name, input int r, input int g, input int b);
        chk({name, " red_cnt"},   32'(red_cnt),   32'(r));
        chk({name, " green_cnt"}, 32'(green_cnt), 32'(g));
        chk({name, " blue_cnt"},  32'(blue_cnt),  32'(b));
    endtask

    task automatic chk_pair(input string name, input int i);
        chk({name, " a_o"},     32'(a_o),     32'(tbl[i].a));
        chk({name, " b_o"},     32'(b_o),     32'(tbl[i].b));
        chk({name, " red_o"},   32'(red_o),   32'(tbl[i].r));
        chk({name, " green_o"}, 32'(green_o), 32'(tbl[i].g));
        chk({name, " blue_o"},  32'(blue_o),  32'(tbl[i].bl));
        chk({name, " busy"},    32'(busy),    32'd1);
    endtask

    initial begin
        int busy_n;
        int n;

        tbl[0]  = '{2'd0, 2'd0, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{2'd0, 2'd1, 1'b0, 1'b1, 1'b1};
        tbl[2]  = '{2'd0, 2'd2, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{2'd0, 2'd3, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{2'd1, 2'd0, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{2'd1, 2'd1, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{2'd1, 2'd2, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{2'd1, 2'd3, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{2'd2, 2'd0, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{2'd2, 2'd1, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{2'd2, 2'd2, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{2'd2, 2'd3, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{2'd3, 2'd0, 1'b1, 1'b0, 1'b1};
        tbl[13] = '{2'd3, 2'd1, 1'b1, 1'b0, 1'b1};
        tbl[14] = '{2'd3, 2'd2, 1'b1, 1'b0, 1'b1};
        tbl[15] = '{2'd3, 2'd3, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; dwell = 8'd0;
        step();
        step();
        // reset state
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst a_o", 32'(a_o), 0);
        chk("rst b_o", 32'(b_o), 0);
        chk("rst colours", 32'({red_o, green_o, blue_o}), 0);
        chk_counts("rst", 0, 0, 0);
        rst = 1'b0;
        step();
        chk("idle busy", 32'(busy), 0);

        // dwell=0 full scan
        dwell = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk_pair($sformatf("d0 pair%0d", i), i);
            chk($sformatf("d0 pair%0d done", i), 32'(done), 0);
            step();
        end
        chk("d0 done pulse", 32'(done), 1);
        chk("d0 done busy", 32'(busy), 0);
        chk("d0 done colours", 32'({red_o, green_o, blue_o}), 0);
        step();
        chk("d0 done one cycle", 32'(done), 0);
        chk("d0 idle busy", 32'(busy), 0);
        chk("d0 a_o hold", 32'(a_o), 3);
        chk("d0 b_o hold", 32'(b_o), 3);
        chk_counts("d0 final", 10, 10, 12);
        step();
        chk_counts("d0 idle hold", 10, 10, 12);

        // dwell=3 full scan
        dwell = 8'd3; start = 1'b1;
        step();
        start = 1'b0;
        dwell = 8'd0;
        for (int c = 0; c < 64; c++) begin
            chk($sformatf("d3 cyc%0d busy", c), 32'(busy), 1);
            chk($sformatf("d3 cyc%0d a_o", c), 32'(a_o), 32'(tbl[c / 4].a));
            chk($sformatf("d3 cyc%0d b_o", c), 32'(b_o), 32'(tbl[c / 4].b));
            step();
        end
        chk("d3 done pulse", 32'(done), 1);
        chk("d3 busy end", 32'(busy), 0);
        step();
        chk_counts("d3 final", 10, 10, 12);

        // abort while index=5, dwell=0
        dwell = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk_counts("ab cleared", 0, 0, 0);
        for (int i = 0; i < 5; i++) step();
        chk("ab at idx5 a_o", 32'(a_o), 1);
        chk("ab at idx5 b_o", 32'(b_o), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab busy", 32'(busy), 0);
        chk("ab done", 32'(done), 0);
        chk("ab colours", 32'({red_o, green_o, blue_o}), 0);
        chk_counts("ab", 2, 4, 4);
        step();
        chk("ab no late done", 32'(done), 0);
        chk("ab stays idle", 32'(busy), 0);

        // start held through scan, dwell changed mid-scan
        dwell = 8'd0; start = 1'b1;
        step();
        busy_n = 0;
        n = 0;
        while (!done && n < 200) begin
            if (n == 2) dwell = 8'd7;
            if (busy) begin
                if (busy_n < 16) chk_pair($sformatf("hold pair%0d", busy_n), busy_n);
                busy_n++;
            end
            step();
            n++;
        end
        chk("hold done seen", 32'(done), 1);
        chk("hold busy length", 32'(busy_n), 16);
        step();
        chk("hold done single", 32'(done), 0);
        chk("hold idle gap", 32'(busy), 0);
        step();
        chk("hold rescan busy", 32'(busy), 1);
        chk("hold rescan a_o", 32'(a_o), 0);
        chk("hold rescan b_o", 32'(b_o), 0);
        chk("hold rescan done", 32'(done), 0);
        start = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;
        chk("hold abort busy", 32'(busy), 0);

        // asynchronous reset mid-scan
        dwell = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        #2 rst = 1'b1;
        #1;
        chk("arst busy", 32'(busy), 0);
        chk("arst done", 32'(done), 0);
        chk("arst a_o", 32'(a_o), 0);
        chk("arst b_o", 32'(b_o), 0);
        chk("arst colours", 32'({red_o, green_o, blue_o}), 0);
        chk_counts("arst", 0, 0, 0);
        step();
        rst = 1'b0;
        step();
        chk("arst no done", 32'(done), 0);
        chk("arst no restart", 32'(busy), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            step();
            n++;
        end
        chk("arst rescan done", 32'(done), 1);
        chk("arst rescan len", 32'(n), 16);
        step();
        chk_counts("arst rescan", 10, 10, 12);

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1;
        step();
        chk("sa busy", 32'(busy), 0);
        step();
        chk("sa busy2", 32'(busy), 0);
        chk("sa done", 32'(done), 0);
        chk_counts("sa", 10, 10, 12);
        start = 1'b0; abort = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tricolor_scan_ctrl.md
TRICOLOR_SCAN_CTRL -- requirements
Module: tricolor_scan_ctrl

Interface
REQ-001 Parameter DWELL_W, default 8, sets the width of the dwell count.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  level-sampled scan request; acted on only in IDLE.
REQ-005 abort  input  1  terminates an active scan.
REQ-006 dwell  input  DWELL_W  extra hold cycles per (a,b) pair; latched at scan start.
REQ-007 a_o  output  2  comparator operand a of the current pair.
REQ-008 b_o  output  2  comparator operand b of the current pair.
REQ-009 red_o, green_o, blue_o  output  1 each  comparator result for (a_o,b_o), gated by busy.
REQ-010 busy  output  1  high while a scan is in progress.
REQ-011 done  output  1  one-cycle pulse on normal scan completion.
REQ-012 red_cnt, green_cnt, blue_cnt  output  5 each  number of scanned pairs with that colour asserted.

Function
REQ-013 Comparator function: red = (a>=b), green = (a<=b), blue = (a!=b), all unsigned 2-bit.
REQ-014 States: IDLE, SCAN, DONE; an encoding of exactly 3 states.
REQ-015 IDLE with start=1 and abort=0 -> SCAN: index=0, hold counter=dwell, dwell latched, all three counts cleared.
REQ-016 Pair order: 4-bit index 0..15; a_o=index[3:2], b_o=index[1:0].
REQ-017 Each pair is held for dwell+1 cycles; dwell=0 gives 1 cycle per pair.
REQ-018 On the last hold cycle of a pair, each count increments by the corresponding comparator bit.
REQ-019 After that cycle the index advances and the hold counter reloads from the latched dwell.
REQ-020 After the last hold cycle of index 15 -> DONE for exactly 1 cycle with done=1 and busy=0, then -> IDLE.
REQ-021 Timing: start sampled at edge k gives busy=1 for cycles k+1 .. k+16*(dwell+1), with the done pulse in the following cycle.
REQ-022 start while in SCAN or DONE is ignored; changes to dwell during a scan are ignored.
REQ-023 abort in SCAN -> IDLE on the next edge. Samples already taken are kept, the pair in progress is not counted, and done stays 0.
REQ-024 abort together with start in IDLE: abort wins and the block stays in IDLE.
REQ-025 Counts hold their values in IDLE and DONE until the next scan start.
REQ-026 Counts are 5 bits; maximum 16; no wrap is possible.
REQ-027 red_o/green_o/blue_o = 0 when busy=0. a_o/b_o hold their last value outside SCAN.

Reset
REQ-028 rst=1 forces IDLE, index=0, hold counter=0, a_o=b_o=0, all counts=0, busy=0, done=0, and all colour outputs 0.
REQ-029 Reset asserted mid-scan aborts immediately without a done pulse; the next scan needs a new start.

Structure
REQ-030 Shared package holds the state enum type, NUM_PAIRS=16, and CNT_W=5.
REQ-031 One sub-module: tricolor, the combinational comparator of REQ-013, instantiated once on (a_o,b_o).
REQ-032 The FSM, index counter, hold counter, and count registers reside in tricolor_scan_ctrl.

Verification
REQ-033 dwell=0, start pulse -> busy for 16 cycles, (a_o,b_o) steps (0,0)..(3,3), then done=1 for 1 cycle; counts red=10, green=10, blue=12.
REQ-034 dwell=3 -> busy for 64 cycles; a_o/b_o change every 4 cycles; final counts 10/10/12.
REQ-035 dwell=0, abort asserted while index=5 -> IDLE next cycle; counts red=2, green=4, blue=4; no done pulse.
REQ-036 start held high throughout a scan and dwell changed mid-scan -> scan length and order unchanged; exactly one done pulse, then a new scan begins after IDLE.
REQ-037 rst asserted mid-scan (asynchronously, between edges) -> all outputs 0 immediately; no done pulse; a subsequent start gives the full 10/10/12 result.
REQ-038 start=1 and abort=1 together in IDLE -> busy stays 0 and counts remain unchanged.
